// File: rtl/pipo_pkg.sv
// Shared constants and width helper for the pipo_fifo block.
package pipo_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 4;

    // Smallest n such that 2**n >= value (0 for value <= 1).
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pipo_fifo_if.sv
// Valid/ready handshake bundle between producer, FIFO and consumer.
interface pipo_fifo_if
    import pipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] din;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dout;
    logic             out_valid;
    logic             out_ready;

    // Producer/consumer side driving the FIFO.
    modport master (
        output din, in_valid, out_ready,
        input  in_ready, dout, out_valid
    );

    // FIFO side.
    modport slave (
        input  din, in_valid, out_ready,
        output in_ready, dout, out_valid
    );

endinterface

// File: rtl/pipo_ram.sv
// DEPTH x WIDTH register array: one write port, asynchronous read port,
// cleared to zero on reset so the head word reads zero after reset.
module pipo_ram
    import pipo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = ceil_log2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage array: zeroed on reset, written on a qualified push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pipo_fifo.sv
// First-word-fall-through FIFO with occupancy, almost-full and sticky
// overflow/underflow reporting. clr flushes pointers, count and flags but
// leaves the storage contents alone.
module pipo_fifo
    import pipo_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEF,
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int AFULL = DEPTH - 1,
    localparam int CW    = ceil_log2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    pipo_fifo_if.slave      bus,
    output logic [CW-1:0]   count,
    output logic            afull,
    output logic            ovf,
    output logic            udf
);

    localparam int AW = ceil_log2(DEPTH);

    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             afull_r;
    logic             ovf_r;
    logic             udf_r;

    logic [AW-1:0]    wr_ptr_nxt_s;
    logic [AW-1:0]    rd_ptr_nxt_s;
    logic [CW-1:0]    count_nxt_s;
    logic             afull_nxt_s;
    logic             ovf_nxt_s;
    logic             udf_nxt_s;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [WIDTH-1:0] rd_data_s;

    // Full/empty come only from registered count, so ready/valid never
    // depend combinationally on the other side's handshake inputs.
    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});

    // A flush discards any transfer offered in the same cycle.
    assign push_s = bus.in_valid  & ~full_s  & ~clr;
    assign pop_s  = bus.out_ready & ~empty_s & ~clr;

    // Next-state for pointers, occupancy and flags; clr overrides everything.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        udf_nxt_s    = udf_r;
        if (clr) begin
            wr_ptr_nxt_s = {AW{1'b0}};
            rd_ptr_nxt_s = {AW{1'b0}};
            count_nxt_s  = {CW{1'b0}};
            ovf_nxt_s    = 1'b0;
            udf_nxt_s    = 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1'b1);
                2'b01:   count_nxt_s = count_r - CW'(1'b1);
                default: count_nxt_s = count_r;
            endcase
            if (bus.in_valid & full_s) begin
                ovf_nxt_s = 1'b1;
            end else begin
                ovf_nxt_s = ovf_r;
            end
            if (bus.out_ready & empty_s) begin
                udf_nxt_s = 1'b1;
            end else begin
                udf_nxt_s = udf_r;
            end
        end
        afull_nxt_s = (count_nxt_s >= CW'(AFULL));
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            afull_r  <= 1'b0;
            ovf_r    <= 1'b0;
            udf_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            afull_r  <= afull_nxt_s;
            ovf_r    <= ovf_nxt_s;
            udf_r    <= udf_nxt_s;
        end
    end

    pipo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (bus.din),
        .raddr (rd_ptr_r),
        .rdata (rd_data_s)
    );

    assign bus.in_ready  = ~full_s;
    assign bus.out_valid = ~empty_s;
    assign bus.dout      = rd_data_s;
    assign count         = count_r;
    assign afull         = afull_r;
    assign ovf           = ovf_r;
    assign udf           = udf_r;

endmodule

// File: tb/tb_pipo_fifo.sv
// Directed plus randomized bench for pipo_fifo (WIDTH=16, DEPTH=4, AFULL=3)
// against a queue-based reference model.
module tb_pipo_fifo;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr   = 1'b0;
    logic [2:0]  count;
    logic        afull;
    logic        ovf;
    logic        udf;

    pipo_fifo_if #(.WIDTH(16)) bus ();

    pipo_fifo #(
        .WIDTH (16),
        .DEPTH (4),
        .AFULL (3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus),
        .count (count),
        .afull (afull),
        .ovf   (ovf),
        .udf   (udf)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] q[$];
    bit          m_ovf = 1'b0;
    bit          m_udf = 1'b0;
    logic [15:0] pat [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string where);
        chk({where, ":in_ready"},  32'(bus.in_ready),  32'(q.size() < 4));
        chk({where, ":out_valid"}, 32'(bus.out_valid), 32'(q.size() > 0));
        chk({where, ":count"},     32'(count),         32'(q.size()));
        chk({where, ":afull"},     32'(afull),         32'(q.size() >= 3));
        chk({where, ":ovf"},       32'(ovf),           32'(m_ovf));
        chk({where, ":udf"},       32'(udf),           32'(m_udf));
        if (q.size() > 0) begin
            chk({where, ":dout"}, 32'(bus.dout), 32'(q[0]));
        end
    endtask

    // One clock cycle: drive at negedge, check pre-edge, advance model, check post-edge.
    task automatic step(input logic iv, input logic [15:0] d, input logic ordy, input logic c);
        bit push;
        bit pop;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.din       = d;
        bus.out_ready = ordy;
        clr           = c;
        #1;
        check_state("pre");
        push = iv && (q.size() < 4) && !c;
        pop  = ordy && (q.size() > 0) && !c;
        @(posedge clk);
        #1;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (iv && q.size() == 4) m_ovf = 1'b1;
            if (ordy && q.size() == 0) m_udf = 1'b1;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(d);
        end
        check_state("post");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.din       = 16'h0000;
        bus.out_ready = 1'b0;
        clr           = 1'b0;
        rst_n         = 1'b0;
        #3;
        chk("reset:dout", 32'(bus.dout), 32'h0);
        check_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-stream with two words queued.
        step(1'b1, 16'hA001, 1'b0, 1'b0);
        step(1'b1, 16'hA002, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        chk("midreset:count",     32'(count),         32'h0);
        chk("midreset:out_valid", 32'(bus.out_valid), 32'h0);
        chk("midreset:in_ready",  32'(bus.in_ready),  32'h1);
        chk("midreset:dout",      32'(bus.dout),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill then drain.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat[i], 1'b0, 1'b0);
            if (i == 2) chk("fill:afull_after_3", 32'(afull), 32'h1);
        end
        chk("fill:in_ready_full", 32'(bus.in_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain:dout", 32'(bus.dout), 32'(pat[i]));
            step(1'b0, 16'h0000, 1'b1, 1'b0);
        end
        chk("drain:out_valid_end", 32'(bus.out_valid), 32'h0);

        // Full with simultaneous push and pop: only the pop happens.
        for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b0);
        chk("fullpp:count", 32'(count),    32'h3);
        chk("fullpp:ovf",   32'(ovf),      32'h1);
        chk("fullpp:head",  32'(bus.dout), 32'h2222);
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Streaming across pointer wrap at count = 1.
        step(1'b1, 16'h7000, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 16'h7001 + 16'(i), 1'b1, 1'b0);
            chk("stream:count", 32'(count), 32'h1);
        end
        step(1'b0, 16'h0000, 1'b1, 1'b0);

        // Underflow, then clear with a push offered the same cycle.
        step(1'b0, 16'h0000, 1'b1, 1'b0);
        chk("udf:set", 32'(udf), 32'h1);
        step(1'b1, 16'hABCD, 1'b0, 1'b1);
        chk("clr:count",     32'(count),         32'h0);
        chk("clr:udf",       32'(udf),           32'h0);
        chk("clr:ovf",       32'(ovf),           32'h0);
        chk("clr:out_valid", 32'(bus.out_valid), 32'h0);
        step(1'b0, 16'h0000, 1'b0, 1'b0);

        // Empty push latency: visible right after the pushing edge.
        chk("lat:out_valid_before", 32'(bus.out_valid), 32'h0);
        step(1'b1, 16'hBEEF, 1'b0, 1'b0);
        chk("lat:dout",      32'(bus.dout),      32'hBEEF);
        chk("lat:out_valid", 32'(bus.out_valid), 32'h1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
